rf_exec_ctrl: RTL and testbench

- Initiator/controller that drives the 8x4-bit two-read/one-write register file.
- Accepts one instruction at a time over a valid/ready handshake and sequences it: read operands on rda1/rda2, compute a 4-bit ALU result, write back via wra/wrd/wr_en.
- Sits between the instruction source (test sequencer or fetch unit) and the register file; register file read data returns combinationally on rdd1/rdd2.

---
 rtl/rf_exec_if.sv | 32 +++
 rtl/rf_exec_ctrl.sv | 122 ++++++++++++
 tb/tb_rf_exec_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_exec_if.sv
// rf_exec_if: instruction handshake plus register-file read/write bus of rf_exec_ctrl.
interface rf_exec_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
);
   logic              instr_valid;
   logic              instr_ready;
   logic [2:0]        instr_op;
   logic [ADDR_W-1:0] instr_dst;
   logic [ADDR_W-1:0] instr_src1;
   logic [ADDR_W-1:0] instr_src2;
   logic [DATA_W-1:0] instr_imm;
   logic [ADDR_W-1:0] rda1;
   logic [ADDR_W-1:0] rda2;
   logic [DATA_W-1:0] rdd1;
   logic [DATA_W-1:0] rdd2;
   logic [ADDR_W-1:0] wra;
   logic [DATA_W-1:0] wrd;
   logic              wr_en;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              flag_zero;
   logic              flag_carry;
   modport master (
      input  instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm, rdd1, rdd2,
      output instr_ready, rda1, rda2, wra, wrd, wr_en, out_valid, out_data, flag_zero, flag_carry
   );
   modport slave (
      output instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm, rdd1, rdd2,
      input  instr_ready, rda1, rda2, wra, wrd, wr_en, out_valid, out_data, flag_zero, flag_carry
   );
endinterface

// File: rtl/rf_exec_ctrl.sv
// rf_exec_ctrl: 4-cycle IDLE/READ/EXEC/WB sequencer driving a 2R1W register file.
// RF_EXEC_CLEAR_EN adds a post-reset CLEAR sweep that zeroes every register.
module rf_exec_ctrl #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
) (
   input logic       clk,
   input logic       reset,
   rf_exec_if.master bus
);
   localparam logic [2:0] OP_NOP = 3'd0, OP_LDI = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_OUT = 3'd7;
   typedef enum logic [2:0] {
      IDLE, READ, EXEC, WB
`ifdef RF_EXEC_CLEAR_EN
      , CLEAR
`endif
   } state_t;
`ifdef RF_EXEC_CLEAR_EN
   localparam state_t RST_ST = CLEAR;
`else
   localparam state_t RST_ST = IDLE;
`endif
   state_t state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [ADDR_W-1:0] dst_q, dst_d, rda1_q, rda1_d, rda2_q, rda2_d, wra_q, wra_d;
   logic [DATA_W-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, wrd_q, wrd_d, out_data_q, out_data_d, res;
   logic zf_q, zf_d, cf_q, cf_d;
   logic [DATA_W:0] sum, diff;
   logic fire, exec, wr_op, alu_op, clr;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RST_ST;
         op_q       <= '0;
         dst_q      <= '0;
         imm_q      <= '0;
         rda1_q     <= '0;
         rda2_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         wra_q      <= '0;
         wrd_q      <= '0;
         out_data_q <= '0;
         zf_q       <= 1'b0;
         cf_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dst_q      <= dst_d;
         imm_q      <= imm_d;
         rda1_q     <= rda1_d;
         rda2_q     <= rda2_d;
         a_q        <= a_d;
         b_q        <= b_d;
         wra_q      <= wra_d;
         wrd_q      <= wrd_d;
         out_data_q <= out_data_d;
         zf_q       <= zf_d;
         cf_q       <= cf_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.instr_valid ? READ : IDLE;
         READ:    state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
`ifdef RF_EXEC_CLEAR_EN
         CLEAR:   state_d = &wra_q ? IDLE : CLEAR;
`endif
         default: state_d = IDLE;
      endcase
   end
   // rda1/rda2 double as the latched source fields: they only change on acceptance
   always_comb begin
      fire   = state_q == IDLE && bus.instr_valid;
      exec   = state_q == EXEC;
      wr_op  = op_q != OP_NOP && op_q != OP_OUT;
      alu_op = op_q inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
      sum    = {1'b0, a_q} + {1'b0, b_q};
      diff   = {1'b0, a_q} - {1'b0, b_q};
      res    = op_q == OP_LDI ? imm_q :
               op_q == OP_ADD ? sum[DATA_W-1:0] :
               op_q == OP_SUB ? diff[DATA_W-1:0] :
               op_q == OP_AND ? a_q & b_q :
               op_q == OP_OR  ? a_q | b_q : a_q;
      op_d       = fire ? bus.instr_op : op_q;
      dst_d      = fire ? bus.instr_dst : dst_q;
      imm_d      = fire ? bus.instr_imm : imm_q;
      rda1_d     = fire ? bus.instr_src1 : rda1_q;
      rda2_d     = fire ? bus.instr_src2 : rda2_q;
      a_d        = state_q == READ ? bus.rdd1 : a_q;
      b_d        = state_q == READ ? bus.rdd2 : b_q;
      wra_d      = exec && wr_op ? dst_q : wra_q;
      wrd_d      = exec && wr_op ? res : wrd_q;
      out_data_d = exec && op_q == OP_OUT ? a_q : out_data_q;
      zf_d       = exec && alu_op ? res == '0 : zf_q;
      cf_d       = exec && op_q == OP_ADD ? sum[DATA_W] :
                   exec && op_q == OP_SUB ? diff[DATA_W] :
                   exec && alu_op ? 1'b0 : cf_q;
`ifdef RF_EXEC_CLEAR_EN
      clr = state_q == CLEAR;
      // wra is the sweep counter; it parks at the top address when the sweep ends
      if (clr) wra_d = &wra_q ? wra_q : wra_q + 1'b1;
`else
      clr = 1'b0;
`endif
   end
   always_comb begin
      bus.instr_ready = !reset && state_q == IDLE;
      bus.wr_en       = !reset && ((state_q == WB && wr_op) || clr);
      bus.out_valid   = !reset && state_q == WB && op_q == OP_OUT;
      bus.rda1        = rda1_q;
      bus.rda2        = rda2_q;
      bus.wra         = wra_q;
      bus.wrd         = wrd_q;
      bus.out_data    = out_data_q;
      bus.flag_zero   = zf_q;
      bus.flag_carry  = cf_q;
   end
endmodule

// File: tb/tb_rf_exec_ctrl.sv
// tb_rf_exec_ctrl: directed checks of rf_exec_ctrl against a behavioural 8x4 register file.
// Also covers the RF_EXEC_CLEAR_EN sweep when that macro is defined.
module tb_rf_exec_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   int wr_snap;
   logic [3:0] rf [8];
   logic [2:0] t4_dst [3] = '{3'd1, 3'd2, 3'd3};
   logic [3:0] t4_imm [3] = '{4'd5, 4'd3, 4'd12};
   rf_exec_if #(.DATA_W(4), .ADDR_W(3)) v ();
   rf_exec_ctrl #(.DATA_W(4), .ADDR_W(3)) dut (.clk(clk), .reset(reset), .bus(v));
   always #5 clk = ~clk;
   assign v.rdd1 = rf[v.rda1];
   assign v.rdd2 = rf[v.rda2];
   always @(posedge clk) begin
      if (v.wr_en) begin
         rf[v.wra] <= v.wrd;
         wr_cnt <= wr_cnt + 1;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   // Presents an instruction, waits for acceptance, and returns in its WB cycle.
   task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [3:0] imm);
      int n;
      n = 0;
      v.instr_op = op;
      v.instr_dst = d;
      v.instr_src1 = s1;
      v.instr_src2 = s2;
      v.instr_imm = imm;
      v.instr_valid = 1'b1;
      while (v.instr_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("accept_wait", 8'(n < 20), 8'd1);
      tick();
      v.instr_valid = 1'b0;
      chk("read_rda1", 8'(v.rda1), 8'(s1));
      chk("read_ready", 8'(v.instr_ready), 8'd0);
      tick();
      tick();
   endtask
   task automatic wb(input string tag, input logic we, input logic [2:0] a, input logic [3:0] d);
      chk({tag, "_wr_en"}, 8'(v.wr_en), 8'(we));
      chk({tag, "_out_valid"}, 8'(v.out_valid), 8'd0);
      if (we) begin
         chk({tag, "_wra"}, 8'(v.wra), 8'(a));
         chk({tag, "_wrd"}, 8'(v.wrd), 8'(d));
      end
   endtask
   task automatic done();
      tick();
      chk("idle_wr_en", 8'(v.wr_en), 8'd0);
      chk("idle_out_valid", 8'(v.out_valid), 8'd0);
      chk("idle_ready", 8'(v.instr_ready), 8'd1);
   endtask
`ifdef RF_EXEC_CLEAR_EN
   task automatic sweep();
      for (int i = 0; i < 8; i++) begin
         chk("clr_wr_en", 8'(v.wr_en), 8'd1);
         chk("clr_wra", 8'(v.wra), 8'(i));
         chk("clr_wrd", 8'(v.wrd), 8'd0);
         chk("clr_ready", 8'(v.instr_ready), 8'd0);
         tick();
      end
      chk("clr_done_ready", 8'(v.instr_ready), 8'd1);
      chk("clr_done_wr_en", 8'(v.wr_en), 8'd0);
   endtask
`endif
   initial begin
      v.instr_valid = 1'b0;
      v.instr_op = '0;
      v.instr_dst = '0;
      v.instr_src1 = '0;
      v.instr_src2 = '0;
      v.instr_imm = '0;
      tick();
      tick();
      chk("rst_ready", 8'(v.instr_ready), 8'd0);
      chk("rst_wr_en", 8'(v.wr_en), 8'd0);
      reset = 1'b0;
      #1;
`ifdef RF_EXEC_CLEAR_EN
      sweep();
      issue(3'd7, 3'd0, 3'd5, 3'd0, 4'd0);
      chk("clr_out_r5_valid", 8'(v.out_valid), 8'd1);
      chk("clr_out_r5_data", 8'(v.out_data), 8'd0);
      done();
`else
      chk("post_rst_ready", 8'(v.instr_ready), 8'd1);
      chk("post_rst_wra", 8'(v.wra), 8'd0);
      chk("post_rst_wrd", 8'(v.wrd), 8'd0);
      chk("post_rst_out_data", 8'(v.out_data), 8'd0);
      chk("post_rst_flags", 8'({v.flag_zero, v.flag_carry}), 8'd0);
`endif
      // Test 1
      issue(3'd1, 3'd1, 3'd0, 3'd0, 4'd5); wb("ldi_r1", 1'b1, 3'd1, 4'd5); done();
      issue(3'd1, 3'd2, 3'd0, 3'd0, 4'd3); wb("ldi_r2", 1'b1, 3'd2, 4'd3); done();
      issue(3'd2, 3'd3, 3'd1, 3'd2, 4'd0); wb("add_r3", 1'b1, 3'd3, 4'd8);
      chk("add_r3_flags", 8'({v.flag_zero, v.flag_carry}), 8'd0);
      done();
      issue(3'd7, 3'd0, 3'd3, 3'd0, 4'd0);
      chk("out_r3_valid", 8'(v.out_valid), 8'd1);
      chk("out_r3_data", 8'(v.out_data), 8'd8);
      chk("out_r3_wr_en", 8'(v.wr_en), 8'd0);
      done();
      issue(3'd0, 3'd0, 3'd0, 3'd0, 4'd0); wb("nop", 1'b0, 3'd0, 4'd0); done();
      // Test 2
      issue(3'd1, 3'd4, 3'd0, 3'd0, 4'd15); wb("ldi_r4", 1'b1, 3'd4, 4'd15); done();
      issue(3'd1, 3'd5, 3'd0, 3'd0, 4'd1); wb("ldi_r5", 1'b1, 3'd5, 4'd1); done();
      issue(3'd2, 3'd6, 3'd4, 3'd5, 4'd0); wb("add_wrap", 1'b1, 3'd6, 4'd0);
      chk("add_wrap_flags", 8'({v.flag_zero, v.flag_carry}), 8'd3);
      done();
      issue(3'd6, 3'd7, 3'd6, 3'd0, 4'd0); wb("mov_r7", 1'b1, 3'd7, 4'd0);
      chk("mov_flags_hold", 8'({v.flag_zero, v.flag_carry}), 8'd3);
      done();
      // Test 3
      issue(3'd3, 3'd0, 3'd2, 3'd1, 4'd0); wb("sub_borrow", 1'b1, 3'd0, 4'd14);
      chk("sub_borrow_flags", 8'({v.flag_zero, v.flag_carry}), 8'd1);
      done();
      issue(3'd3, 3'd0, 3'd1, 3'd2, 4'd0); wb("sub_plain", 1'b1, 3'd0, 4'd2);
      chk("sub_plain_flags", 8'({v.flag_zero, v.flag_carry}), 8'd0);
      done();
      issue(3'd4, 3'd0, 3'd1, 3'd2, 4'd0); wb("and", 1'b1, 3'd0, 4'd1); done();
      issue(3'd5, 3'd0, 3'd1, 3'd2, 4'd0); wb("or", 1'b1, 3'd0, 4'd7);
      chk("or_flags", 8'({v.flag_zero, v.flag_carry}), 8'd0);
      done();
      // Test 4: valid held high, back-to-back LDIs accepted every 4 cycles
      v.instr_valid = 1'b1;
      v.instr_op = 3'd1;
      for (int k = 0; k < 3; k++) begin
         v.instr_dst = t4_dst[k];
         v.instr_imm = t4_imm[k];
         chk("t4_ready_hi", 8'(v.instr_ready), 8'd1);
         tick();
         if (k == 2) v.instr_valid = 1'b0;
         chk("t4_read_ready", 8'(v.instr_ready), 8'd0);
         tick();
         chk("t4_exec_ready", 8'(v.instr_ready), 8'd0);
         chk("t4_exec_wr_en", 8'(v.wr_en), 8'd0);
         tick();
         chk("t4_wb_ready", 8'(v.instr_ready), 8'd0);
         wb("t4_wb", 1'b1, t4_dst[k], t4_imm[k]);
         tick();
      end
      chk("t4_end_ready", 8'(v.instr_ready), 8'd1);
      // Test 5: reset during EXEC of ADD r3,r1,r2 abandons it
      wr_snap = wr_cnt;
      v.instr_op = 3'd2;
      v.instr_dst = 3'd3;
      v.instr_src1 = 3'd1;
      v.instr_src2 = 3'd2;
      v.instr_valid = 1'b1;
      tick();
      v.instr_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("t5_rst_wr_en", 8'(v.wr_en), 8'd0);
      chk("t5_rst_ready", 8'(v.instr_ready), 8'd0);
      tick();
      reset = 1'b0;
      #1;
`ifdef RF_EXEC_CLEAR_EN
      sweep();
      chk("t5_wr_count", 8'(wr_cnt - wr_snap), 8'd8);
      issue(3'd7, 3'd0, 3'd3, 3'd0, 4'd0);
      chk("t5_out_r3", 8'(v.out_data), 8'd0);
`else
      chk("t5_ready", 8'(v.instr_ready), 8'd1);
      chk("t5_wr_en", 8'(v.wr_en), 8'd0);
      chk("t5_wrd", 8'(v.wrd), 8'd0);
      chk("t5_wra", 8'(v.wra), 8'd0);
      tick();
      chk("t5_wr_en_after", 8'(v.wr_en), 8'd0);
      chk("t5_wr_count", 8'(wr_cnt - wr_snap), 8'd0);
      issue(3'd7, 3'd0, 3'd3, 3'd0, 4'd0);
      chk("t5_out_r3", 8'(v.out_data), 8'd12);
`endif
      chk("t5_out_valid", 8'(v.out_valid), 8'd1);
      done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
